// File: rtl/instr_encoder_if.sv
// Handshake/bus bundle for instr_encoder: decoded-field input side, encoded-word output side.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_fmt;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [2:0]           in_funct3;
  logic [6:0]           in_funct7;
  logic [31:0]          in_imm;
  logic                 addr_load;
  logic [ADDR_W-1:0]    addr_base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [ADDR_W-1:0]    out_addr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  // Program loader side
  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output addr_load, addr_base, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  // Encoder side
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  addr_load, addr_base, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with immediate range check, 2-entry output buffer and address tagging.
// Optional macro INSTR_ENC_DROP_ERR_EN: erroneous words are counted but discarded instead of emitted.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 2;
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
    logic               err;
  } entry_t;

  logic [CNT_W-1:0]     count_q, count_d;
  entry_t               head_q, head_d;
  entry_t               tail_q, tail_d;
  logic                 out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [INSTR_W-1:0]   imm;
  logic [INSTR_W-1:0]   instr_c;
  logic                 err_c;
  logic                 drop_c;
  logic                 accept_c;
  logic                 push_c;
  logic                 pop_c;
  logic [ADDR_W-1:0]    word_addr_c;
  entry_t               entry_new_c;

  assign imm = bus.in_imm;

  // Field packing and immediate range check
  always_comb begin
    instr_c = NOP;
    err_c   = 1'b1;
    case (bus.in_fmt)
      FMT_R: begin
        instr_c = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        err_c   = 1'b0;
      end
      FMT_I: begin
        instr_c = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        err_c   = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_S: begin
        instr_c = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
        err_c   = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_B: begin
        instr_c = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   imm[4:1], imm[11], bus.in_opcode};
        err_c   = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      FMT_U: begin
        instr_c = {imm[31:12], bus.in_rd, bus.in_opcode};
        err_c   = |imm[11:0];
      end
      FMT_J: begin
        instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        err_c   = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      default: begin
        instr_c = NOP;
        err_c   = 1'b1;
      end
    endcase
  end

`ifdef INSTR_ENC_DROP_ERR_EN
  assign drop_c = err_c;
`else
  assign drop_c = 1'b0;
`endif

  // Occupancy-only ready keeps out_ready off the input timing path
  assign bus.in_ready = (count_q < CNT_W'(2));

  assign accept_c    = bus.in_valid && bus.in_ready;
  assign push_c      = accept_c && !drop_c;
  assign pop_c       = out_valid_q && bus.out_ready;
  assign word_addr_c = bus.addr_load ? bus.addr_base : addr_q;

  always_comb begin
    entry_new_c.instr = instr_c;
    entry_new_c.addr  = word_addr_c;
`ifdef INSTR_ENC_DROP_ERR_EN
    entry_new_c.err   = 1'b0;
`else
    entry_new_c.err   = err_c;
`endif
  end

  // Next-state: buffer shift, address counter, error counter
  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    addr_d      = addr_q;
    err_cnt_d   = err_cnt_q;
    out_valid_d = out_valid_q;

    if (push_c) begin
      addr_d = word_addr_c + ADDR_W'(4);
    end else if (bus.addr_load) begin
      addr_d = bus.addr_base;
    end

    if (accept_c && err_c && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    // Head only moves on pop; when the buffer drains it keeps its last contents
    if (pop_c && (count_q == CNT_W'(2))) begin
      head_d = tail_q;
    end

    if (push_c) begin
      if ((count_q == CNT_W'(0)) || ((count_q == CNT_W'(1)) && pop_c)) begin
        head_d = entry_new_c;
      end else begin
        tail_d = entry_new_c;
      end
    end

    count_d     = CNT_W'(count_q + CNT_W'(push_c) - CNT_W'(pop_c));
    out_valid_d = (count_d != CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      err_cnt_q   <= '0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = head_q.instr;
  assign bus.out_addr  = head_q.addr;
  assign bus.out_err   = head_q.err;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (default build, drop macro undefined).
module tb_instr_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  instr_encoder_if #(.ADDR_W(16), .ERR_CNT_W(8)) bus ();

  instr_encoder #(.ADDR_W(16), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word at a negedge, wait (bounded) for ready, return at the negedge after the accept.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic ld, input logic [15:0] base);
    int n;
    bus.in_fmt = fmt; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
    bus.addr_load = ld; bus.addr_base = base; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready stayed %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.addr_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", bus.out_instr); end
    checks++; if (bus.out_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.out_addr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.out_err); end
    checks++; if (bus.err_count !== 8'h0) begin failures++; $display("FAIL rst_errcnt got=%h exp=0", bus.err_count); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5, 1'b0, 16'h0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL i_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h00500093) begin failures++; $display("FAIL i_instr got=%h exp=00500093", bus.out_instr); end
    checks++; if (bus.out_addr !== 16'h0000) begin failures++; $display("FAIL i_addr got=%h exp=0000", bus.out_addr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL i_err got=%b exp=0", bus.out_err); end
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, 32'd8, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h0020A423) begin failures++; $display("FAIL s_instr got=%h exp=0020a423", bus.out_instr); end
    checks++; if (bus.out_addr !== 16'h0004) begin failures++; $display("FAIL s_addr got=%h exp=0004", bus.out_addr); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0020A423) begin failures++; $display("FAIL hold_instr got=%h exp=0020a423", bus.out_instr); end
    checks++; if (bus.out_addr !== 16'h0004) begin failures++; $display("FAIL hold_addr got=%h exp=0004", bus.out_addr); end
  endtask

  task automatic test_errors();
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h12345000, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h123452B7) begin failures++; $display("FAIL u_instr got=%h exp=123452b7", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL u_err got=%b exp=0", bus.out_err); end
    checks++; if (bus.out_addr !== 16'h0008) begin failures++; $display("FAIL u_addr got=%h exp=0008", bus.out_addr); end
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h12345001, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h123452B7) begin failures++; $display("FAIL ubad_instr got=%h exp=123452b7", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL ubad_err got=%b exp=1", bus.out_err); end
    checks++; if (bus.err_count !== 8'd1) begin failures++; $display("FAIL ubad_cnt got=%0d exp=1", bus.err_count); end
    checks++; if (bus.out_addr !== 16'h000C) begin failures++; $display("FAIL ubad_addr got=%h exp=000c", bus.out_addr); end
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h80000093) begin failures++; $display("FAIL ibad_instr got=%h exp=80000093", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL ibad_err got=%b exp=1", bus.out_err); end
    checks++; if (bus.err_count !== 8'd2) begin failures++; $display("FAIL ibad_cnt got=%0d exp=2", bus.err_count); end
  endtask

  task automatic test_formats();
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'hFFFFFFFC, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'hFE208EE3) begin failures++; $display("FAIL b_instr got=%h exp=fe208ee3", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL b_err got=%b exp=0", bus.out_err); end
    checks++; if (bus.out_addr !== 16'h0014) begin failures++; $display("FAIL b_addr got=%h exp=0014", bus.out_addr); end
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'd3, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h00208163) begin failures++; $display("FAIL bodd_instr got=%h exp=00208163", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL bodd_err got=%b exp=1", bus.out_err); end
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd8, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h008000EF) begin failures++; $display("FAIL j_instr got=%h exp=008000ef", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL j_err got=%b exp=0", bus.out_err); end
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h00100000, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h800000EF) begin failures++; $display("FAIL jbig_instr got=%h exp=800000ef", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL jbig_err got=%b exp=1", bus.out_err); end
    checks++; if (bus.err_count !== 8'd4) begin failures++; $display("FAIL jbig_cnt got=%0d exp=4", bus.err_count); end
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h402081B3) begin failures++; $display("FAIL r_instr got=%h exp=402081b3", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL r_err got=%b exp=0", bus.out_err); end
    send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h00000013) begin failures++; $display("FAIL ill_instr got=%h exp=00000013", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", bus.out_err); end
    checks++; if (bus.err_count !== 8'd5) begin failures++; $display("FAIL ill_cnt got=%0d exp=5", bus.err_count); end
    checks++; if (bus.out_addr !== 16'h0028) begin failures++; $display("FAIL ill_addr got=%h exp=0028", bus.out_addr); end
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFFF800, 1'b0, 16'h0);
    checks++; if (bus.out_instr !== 32'h80000093) begin failures++; $display("FAIL ineg_instr got=%h exp=80000093", bus.out_instr); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL ineg_err got=%b exp=0", bus.out_err); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1, 1'b1, 16'h0000);
    checks++; if (bus.out_addr !== 16'h0000) begin failures++; $display("FAIL bp_addr0 got=%h exp=0000", bus.out_addr); end
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2, 1'b0, 16'h0);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_instr !== 32'h00100093) begin failures++; $display("FAIL bp_head got=%h exp=00100093", bus.out_instr); end
    bus.in_imm = 32'd3;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_held_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_addr !== 16'h0000) begin failures++; $display("FAIL bp_held_addr got=%h exp=0000", bus.out_addr); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_instr !== 32'h00200093) begin failures++; $display("FAIL bp_pop1_instr got=%h exp=00200093", bus.out_instr); end
    checks++; if (bus.out_addr !== 16'h0004) begin failures++; $display("FAIL bp_pop1_addr got=%h exp=0004", bus.out_addr); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_instr !== 32'h00300093) begin failures++; $display("FAIL bp_third_instr got=%h exp=00300093", bus.out_instr); end
    checks++; if (bus.out_addr !== 16'h0008) begin failures++; $display("FAIL bp_third_addr got=%h exp=0008", bus.out_addr); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_addr();
    bus.addr_load = 1'b1;
    bus.addr_base = 16'h0200;
    @(negedge clk);
    bus.addr_load = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd4, 1'b0, 16'h0);
    checks++; if (bus.out_addr !== 16'h0200) begin failures++; $display("FAIL ld_addr got=%h exp=0200", bus.out_addr); end
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5, 1'b1, 16'hFFFC);
    checks++; if (bus.out_addr !== 16'hFFFC) begin failures++; $display("FAIL ldacc_addr got=%h exp=fffc", bus.out_addr); end
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd6, 1'b0, 16'h0);
    checks++; if (bus.out_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h exp=0000", bus.out_addr); end
    checks++; if (bus.out_instr !== 32'h00600093) begin failures++; $display("FAIL wrap_instr got=%h exp=00600093", bus.out_instr); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0, 1'b1, 16'h0040);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd7, 1'b0, 16'h0);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rm_full got=%b exp=0", bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL rm_cnt got=%0d exp=0", bus.err_count); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL rm_instr got=%h exp=0", bus.out_instr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1, 1'b0, 16'h0);
    checks++; if (bus.out_addr !== 16'h0000) begin failures++; $display("FAIL rm_next_addr got=%h exp=0000", bus.out_addr); end
    checks++; if (bus.out_instr !== 32'h00100093) begin failures++; $display("FAIL rm_next_instr got=%h exp=00100093", bus.out_instr); end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 255; i++) begin
      send(3'd7, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0, 1'b0, 16'h0);
    end
    checks++; if (bus.err_count !== 8'hFF) begin failures++; $display("FAIL sat_reach got=%0d exp=255", bus.err_count); end
    send(3'd7, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0, 1'b0, 16'h0);
    checks++; if (bus.err_count !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%0d exp=255", bus.err_count); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_fmt = 3'd0; bus.in_opcode = 7'h0; bus.in_rd = 5'd0;
    bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_funct3 = 3'd0; bus.in_funct7 = 7'h0;
    bus.in_imm = 32'h0; bus.addr_load = 1'b0; bus.addr_base = 16'h0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_errors();
    test_formats();
    test_backpressure();
    test_addr();
    test_reset_mid();
    test_err_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator. Takes decoded instruction fields plus a full 32-bit immediate, range-checks the immediate, and packs everything into a 32-bit RV32I instruction word.
- Output is a 2-entry buffer with a valid/ready handshake. Each word is tagged with an auto-incrementing instruction-memory byte address.
- Used by the test/debug program loader to write instruction memory without pre-assembled images.

Parameters:
- ADDR_W, 16, width of the out_addr byte-address counter.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input fields valid.
- in_ready  output  1  encoder can accept this cycle.
- in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal.
- in_opcode  input  7  opcode field, copied to instr[6:0].
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field (R only).
- in_imm  input  32  signed immediate, byte offset for B/J, full value for U.
- addr_load  input  1  load address counter from addr_base.
- addr_base  input  ADDR_W  new base byte address.
- out_valid  output  1  buffer head valid.
- out_ready  input  1  consumer accepts head.
- out_instr  output  32  encoded instruction at head.
- out_addr  output  ADDR_W  byte address of head.
- out_err  output  1  head instruction failed the range check.
- err_count  output  ERR_CNT_W  saturating count of range errors.

Behaviour:
- Reset (async, rst_n=0):
  - Buffer emptied: out_valid=0, out_instr=0, out_addr=0, out_err=0.
  - err_count=0, address counter=0.
  - in_ready=1 from the first edge after release.
- Handshakes:
  - Accept when in_valid && in_ready at a rising edge.
  - Pop when out_valid && out_ready.
  - in_ready = buffer occupancy < 2; combinational from registered occupancy only, with no path from out_ready.
- Latency: a word accepted at edge N is visible on the out_* ports after edge N, i.e. 1 cycle when the buffer is empty.
- Buffer: 2 entries, FIFO order.
  - Push and pop in the same cycle leave occupancy unchanged.
  - When full, in_ready=0, so no push can occur while full.
  - When empty, out_valid=0 and out_* hold their last values.
- Encoding, with imm = in_imm:
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - Illegal fmt: instr = 32'h0000_0013 (nop).
- Range check (err=1 when violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: never errors; in_imm ignored.
  - Illegal fmt: always errors.
  - An erroneous word is still encoded from the truncated bits and carries out_err=1.
- Address counter:
  - Each accepted word takes the current counter value; the counter then advances by 4.
  - Wraps modulo 2^ADDR_W.
  - addr_load alone: counter <= addr_base.
  - addr_load in the same cycle as an accept: the accepted word gets addr_base, and counter <= addr_base+4.
- err_count: +1 per accepted erroneous word, saturating at all-ones.
- Reset mid-operation: buffered words are discarded; no partial output.

Optional Feature:
- Macro: INSTR_ENC_DROP_ERR_EN.
- Defined: erroneous words are accepted (in_ready unaffected) but not pushed, the address counter does not advance, and err_count still increments. out_err is tied to 0.
- Undefined: behaviour as above; errors pass through tagged with out_err.

Test Plan:
- I-type: fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=5, out_ready=1 -> out_instr=0x00500093, out_addr=0, out_err=0, one cycle after accept.
- S-type: fmt=2, op=0x23, f3=2, rs1=1, rs2=2, imm=8 after the word above -> out_instr=0x0020A423, out_addr=4.
- U-type: fmt=4, op=0x37, rd=5, imm=0x12345000 -> out_instr=0x123452B7. The same with imm=0x12345001 -> out_err=1, err_count=1. I-type imm=2048 -> out_err=1, err_count=2. With the macro defined, neither erroneous word appears and the address does not advance.
- Backpressure: out_ready=0 with 3 back-to-back inputs -> in_ready=0 after 2 accepts (addresses 0, 4); third held. out_ready=1 -> pops in order, third gets address 8.
- Address: addr_load=1, addr_base=0xFFFC together with an accept -> word at 0xFFFC, next word at 0x0000 (wrap).
- Reset: rst_n=0 asserted with 2 buffered words -> out_valid=0 immediately; err_count=0; next accept gets addr 0.
